// File: rtl/dmem_arbiter_if.sv
// Requester-side and dmem-side signals of the two-port data-memory arbiter.
// slave = arbiter view; master = requesters plus the memory they share.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wd0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wd
  );

  modport master (
    output req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-capped owner FSM sharing one single-port dmem between two requesters.
// gnt one cycle after req from IDLE, rdata one cycle after the access; requesters hold req until granted.
module dmem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int            CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          acc0, acc1;

  assign acc0 = (state_q == OWN0) && bus.req0;
  assign acc1 = (state_q == OWN1) && bus.req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? OWN1 : IDLE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (bus.req1 && (cnt_q == CNT_MAX)) begin
          state_d = OWN1;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? OWN0 : IDLE;
          cnt_d   = '0;
          last_d  = 1'b1;
        end else if (bus.req0 && (cnt_q == CNT_MAX)) begin
          state_d = OWN0;
          cnt_d   = '0;
          last_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Address/data follow the owner; the write strobe also needs a live request and no reset.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    case (state_q)
      OWN0: begin
        bus.mem_addr = bus.addr0;
        bus.mem_wd   = bus.wd0;
        bus.mem_we   = bus.we0 && bus.req0 && !reset;
      end
      OWN1: begin
        bus.mem_addr = bus.addr1;
        bus.mem_wd   = bus.wd1;
        bus.mem_we   = bus.we1 && bus.req1 && !reset;
      end
      default: ;
    endcase
  end

  always_comb begin
    rvalid0_d = acc0 && !bus.we0;
    rvalid1_d = acc1 && !bus.we1;
    rdata0_d  = rvalid0_d ? bus.mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rd : rdata1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.gnt0    = (state_q == OWN0);
  assign bus.gnt1    = (state_q == OWN1);
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: owner/shadow-memory model checked every cycle plus literal scenario checks.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // The shared memory the arbiter drives.
  logic [DW-1:0] dmem [0:1023];
  assign bus.mem_rd = dmem[bus.mem_addr];
  always @(posedge clock) if (bus.mem_we === 1'b1) dmem[bus.mem_addr] <= bus.mem_wd;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h11;
  endfunction

  // Model: who owns memory, how long it has owned it, and the data each port should see.
  int            m_owner, m_served, m_last, oth;
  logic          m_rv [2];
  logic [31:0]   m_rd [2];
  logic [31:0]   shadow [0:1023];
  bit            model_valid = 1'b0;
  logic          mreq [2];
  logic          mwe  [2];
  logic [AW-1:0] maddr [2];
  logic [31:0]   mwd  [2];
  logic          macc, e_we;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wd;

  always @(negedge clock) begin
    mreq[0] = bus.req0;  mwe[0] = bus.we0;  maddr[0] = bus.addr0;  mwd[0] = bus.wd0;
    mreq[1] = bus.req1;  mwe[1] = bus.we1;  maddr[1] = bus.addr1;  mwd[1] = bus.wd1;
    if (bus.mem_we === 1'b1) we_cnt++;
    macc = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (model_valid) begin
      if (m_owner >= 0) begin
        macc   = mreq[m_owner];
        e_addr = maddr[m_owner];
        e_wd   = mwd[m_owner];
        e_we   = macc && mwe[m_owner] && !reset;
      end
      check("cyc_gnt0",    32'(bus.gnt0),    32'(m_owner == 0));
      check("cyc_gnt1",    32'(bus.gnt1),    32'(m_owner == 1));
      check("cyc_rvalid0", 32'(bus.rvalid0), 32'(m_rv[0]));
      check("cyc_rvalid1", 32'(bus.rvalid1), 32'(m_rv[1]));
      check("cyc_rdata0",  bus.rdata0,       m_rd[0]);
      check("cyc_rdata1",  bus.rdata1,       m_rd[1]);
      check("cyc_mem_we",  32'(bus.mem_we),  32'(e_we));
      check("cyc_mem_addr",32'(bus.mem_addr),32'(e_addr));
      check("cyc_mem_wd",  bus.mem_wd,       e_wd);
    end
    if (reset) begin
      m_owner = -1; m_served = 0; m_last = 1;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (macc) begin
        if (mwe[m_owner]) shadow[maddr[m_owner]] = mwd[m_owner];
        else begin
          m_rv[m_owner] = 1'b1;
          m_rd[m_owner] = shadow[maddr[m_owner]];
        end
      end
      if (m_owner < 0) begin
        if (mreq[0] && mreq[1]) m_owner = 1 - m_last;
        else if (mreq[0])       m_owner = 0;
        else if (mreq[1])       m_owner = 1;
        m_served = 0;
      end else begin
        oth = 1 - m_owner;
        m_served++;
        if (!mreq[m_owner]) begin
          m_last = m_owner; m_owner = mreq[oth] ? oth : -1; m_served = 0;
        end else if (mreq[oth] && m_served >= MB) begin
          m_last = m_owner; m_owner = oth; m_served = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_port(input int p, input logic rq, input logic w,
                          input logic [AW-1:0] a, input logic [31:0] d);
    if (p == 0) begin bus.req0 = rq; bus.we0 = w; bus.addr0 = a; bus.wd0 = d; end
    else        begin bus.req1 = rq; bus.we1 = w; bus.addr1 = a; bus.wd1 = d; end
  endtask

  function automatic logic get_gnt(input int p);
    return (p == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  // One access: wait (bounded) for the grant, let it commit, then drop the request.
  task automatic do_access(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [31:0] d, output int n);
    set_port(p, 1'b1, w, a, d);
    #1;
    n = 0;
    while (!get_gnt(p) && n < 20) begin tick(); n++; end
    if (!get_gnt(p)) check("access_grant_timeout", 32'(get_gnt(p)), 32'd1);
    tick();
    set_port(p, 1'b0, w, a, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  int          n, w0, gcnt, rvcnt;
  logic [15:0] g0, g1;
  logic [31:0] exp_d;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i]   = init_val(i);
      shadow[i] = init_val(i);
    end
    dmem[5]   = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("reset_gnt0",    32'(bus.gnt0),    32'd0);
    check("reset_gnt1",    32'(bus.gnt1),    32'd0);
    check("reset_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("reset_rdata1",  bus.rdata1,       32'd0);
    reset = 1'b0;

    // 1: read from IDLE, gnt at N+1, data at N+2
    do_access(0, 1'b0, 10'd5, 32'd0, n);
    check("t1_grant_latency", 32'(n), 32'd1);
    check("t1_rvalid0", 32'(bus.rvalid0), 32'd1);
    check("t1_rdata0",  bus.rdata0, 32'hDEADBEEF);
    tick(); tick();

    // 2: write then read back
    w0 = we_cnt;
    do_access(0, 1'b1, 10'd3, 32'h12345678, n);
    check("t2_write_pulses", 32'(we_cnt - w0), 32'd1);
    check("t2_no_rvalid_on_write", 32'(bus.rvalid0), 32'd0);
    tick();
    do_access(0, 1'b0, 10'd3, 32'd0, n);
    check("t2_rvalid0", 32'(bus.rvalid0), 32'd1);
    check("t2_rdata0",  bus.rdata0, 32'h12345678);
    tick(); tick();

    // 3: contention from IDLE after reset, bursts of 4 alternate
    do_reset();
    set_port(0, 1'b1, 1'b0, 10'd7, '0);
    set_port(1, 1'b1, 1'b0, 10'd8, '0);
    g0 = '0; g1 = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      g0[k] = bus.gnt0;
      g1[k] = bus.gnt1;
    end
    check("t3_gnt0_pattern", 32'(g0), 32'h0000_0F0F);
    check("t3_gnt1_pattern", 32'(g1), 32'h0000_F0F0);
    check("t3_never_both",   32'(g0 & g1), 32'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();

    // 4: port 1 alone streams 10 reads without a burst cap
    do_reset();
    set_port(1, 1'b1, 1'b0, 10'd0, '0);
    #1;
    n = 0;
    while (!bus.gnt1 && n < 20) begin tick(); n++; end
    check("t4_grant_latency", 32'(n), 32'd1);
    gcnt = 0; rvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.addr1 = 10'(i);
      if (bus.gnt1) gcnt++;
      tick();
      if (bus.rvalid1) rvcnt++;
      exp_d = (i == 3) ? 32'h12345678 : (i == 5) ? 32'hDEADBEEF : init_val(i);
      check("t4_rdata1", bus.rdata1, exp_d);
    end
    check("t4_gnt1_cycles", 32'(gcnt), 32'd10);
    check("t4_rvalid1_pulses", 32'(rvcnt), 32'd10);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();

    // 5: reset in the middle of a port-1 write burst
    do_reset();
    set_port(1, 1'b1, 1'b1, 10'd20, 32'hA0A0_0020);
    #1;
    n = 0;
    while (!bus.gnt1 && n < 20) begin tick(); n++; end
    tick();
    set_port(1, 1'b1, 1'b1, 10'd21, 32'hA0A0_0021);
    tick();
    set_port(1, 1'b1, 1'b1, 10'd22, 32'hA0A0_0022);
    reset = 1'b1;
    #1;
    check("t5_no_we_in_reset", 32'(bus.mem_we), 32'd0);
    tick();
    reset = 1'b0;
    set_port(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("t5_gnt1_after_reset",   32'(bus.gnt1),    32'd0);
    check("t5_rvalid1_after_reset",32'(bus.rvalid1), 32'd0);
    check("t5_dmem20", dmem[20], 32'hA0A0_0020);
    check("t5_dmem21", dmem[21], 32'hA0A0_0021);
    check("t5_dmem22_unchanged", dmem[22], init_val(22));
    tick(); tick();

    // 6: after port 0 was last served, a simultaneous request goes to port 1
    do_access(0, 1'b0, 10'd9, 32'd0, n);
    tick(); tick();
    set_port(0, 1'b1, 1'b0, 10'd1, '0);
    set_port(1, 1'b1, 1'b0, 10'd2, '0);
    #1;
    check("t6_idle_gnt1", 32'(bus.gnt1), 32'd0);
    tick();
    check("t6_gnt1_first", 32'(bus.gnt1), 32'd1);
    check("t6_gnt0_waits", 32'(bus.gnt0), 32'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
